// File: rtl/bram_comm_pkg.sv
// Shared constants and reader state type for the BRAM communication unit.
package bram_comm_pkg;

  localparam logic [31:0] DEF_KERNEL_ADDR = 32'hA000_0000;
  localparam logic [31:0] DEF_IMAGE_ADDR  = 32'hA000_0024;
  localparam logic [31:0] DEF_OUT_ADDR    = 32'hA000_1000;
  localparam int DEF_KERNEL_SIZE = 9;
  localparam int DEF_IMAGE_SIZE  = 16;
  localparam int DEF_NUM_IMAGES  = 3;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD_KERNEL, STREAM_IMAGE} reader_state_t;

  function automatic int pix_per_word(input int dw, input int ps);
    return dw / ps;
  endfunction

endpackage

// File: rtl/bram_reader.sv
// Reads the kernel into a register bank and streams image words out as pixels.
module bram_reader
  import bram_comm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] KERNEL_ADDR = DEF_KERNEL_ADDR,
  parameter logic [ADDR_WIDTH-1:0] IMAGE_ADDR = DEF_IMAGE_ADDR,
  parameter int PIXEL_SIZE = 8,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int IMAGE_SIZE = DEF_IMAGE_SIZE,
  parameter int NUM_IMAGES = DEF_NUM_IMAGES
) (
  input  logic                                   clk,
  input  logic                                   reset,
  output logic [ADDR_WIDTH-1:0]                  rd_addr,
  input  logic [DATA_WIDTH-1:0]                  rd_data,
  input  logic                                   read_kernel,
  input  logic                                   read_image,
  input  logic                                   interrupt,
  output logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] kernel,
  output logic [PIXEL_SIZE-1:0]                  pixel,
  output logic                                   pixel_valid
);

  localparam int PIX_PER_WORD = pix_per_word(DATA_WIDTH, PIXEL_SIZE);
  localparam int IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIX_PER_WORD - 1);
  localparam logic [CNT_W-1:0] KERNEL_CAP_LAST = CNT_W'(KERNEL_SIZE);
  localparam logic [CNT_W-1:0] KERNEL_ISSUE_LAST = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [CNT_W-1:0] WORDS_LAST = CNT_W'(IMAGE_SIZE * NUM_IMAGES - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  reader_state_t         state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      byte_idx;
  logic                  warm;
  logic [DATA_WIDTH-1:0] cur_word;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rd_addr     <= '0;
      kernel      <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      cnt         <= '0;
      byte_idx    <= '0;
      warm        <= 1'b0;
      cur_word    <= '0;
    end else begin
      case (state)
        IDLE: begin
          pixel_valid <= 1'b0;
          cnt         <= '0;
          byte_idx    <= '0;
          warm        <= 1'b0;
          if (read_kernel) begin
            state   <= LOAD_KERNEL;
            rd_addr <= KERNEL_ADDR;
          end else if (read_image) begin
            state   <= STREAM_IMAGE;
            rd_addr <= IMAGE_ADDR;
          end
        end
        LOAD_KERNEL: begin
          // cnt-1 is the word whose data is on rd_data this cycle
          cnt <= cnt + 1'b1;
          if (cnt < KERNEL_ISSUE_LAST) rd_addr <= rd_addr + WORD_STEP;
          for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (cnt == CNT_W'(i + 1)) kernel[i] <= rd_data;
          end
          if (cnt == KERNEL_CAP_LAST) state <= IDLE;
        end
        STREAM_IMAGE: begin
          if (!warm) begin
            warm        <= 1'b1;
            pixel_valid <= 1'b0;
          end else if (interrupt) begin
            pixel_valid <= 1'b0;
          end else begin
            pixel_valid <= 1'b1;
            if (byte_idx == '0) begin
              // Latch the word and prefetch the next one while its bytes drain.
              pixel    <= rd_data[PIXEL_SIZE-1:0];
              cur_word <= rd_data;
              if (cnt != WORDS_LAST) rd_addr <= rd_addr + WORD_STEP;
            end else begin
              for (int i = 1; i < PIX_PER_WORD; i++) begin
                if (byte_idx == IDX_W'(i)) pixel <= cur_word[i*PIXEL_SIZE +: PIXEL_SIZE];
              end
            end
            if (byte_idx == IDX_LAST) begin
              byte_idx <= '0;
              cnt      <= cnt + 1'b1;
              if (cnt == WORDS_LAST) state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bram_writer.sv
// Packs result pixels LSB-first into words and writes them to the result area.
module bram_writer
  import bram_comm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] OUT_ADDR = DEF_OUT_ADDR,
  parameter int PIXEL_SIZE = 8,
  parameter int IMAGE_SIZE = DEF_IMAGE_SIZE,
  parameter int NUM_IMAGES = DEF_NUM_IMAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIXEL_SIZE-1:0] wr_pixel,
  input  logic                  wr_pixel_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [3:0]            write_enable,
  output logic                  conv_done
);

  localparam int PIX_PER_WORD = pix_per_word(DATA_WIDTH, PIXEL_SIZE);
  localparam int IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] SLOT_LAST = IDX_W'(PIX_PER_WORD - 1);
  localparam logic [CNT_W-1:0] WORDS_LAST = CNT_W'(IMAGE_SIZE * NUM_IMAGES - 1);

  logic [DATA_WIDTH-1:0] pack_word;
  logic [DATA_WIDTH-1:0] packed_next;
  logic [IDX_W-1:0]      slot;
  logic [CNT_W-1:0]      word_cnt;
  logic                  last_wr;

  always_comb begin
    packed_next = pack_word;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (slot == IDX_W'(i)) packed_next[i*PIXEL_SIZE +: PIXEL_SIZE] = wr_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pack_word    <= '0;
      slot         <= '0;
      word_cnt     <= '0;
      last_wr      <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      write_enable <= 4'h0;
      conv_done    <= 1'b0;
    end else begin
      write_enable <= 4'h0;
      last_wr      <= 1'b0;
      // Done trails the final write strobe by one cycle.
      conv_done    <= last_wr;
      if (wr_pixel_valid) begin
        pack_word <= packed_next;
        if (slot == SLOT_LAST) begin
          slot         <= '0;
          wr_data      <= packed_next;
          wr_addr      <= OUT_ADDR + ADDR_WIDTH'({word_cnt, 2'b00});
          write_enable <= 4'hF;
          if (word_cnt == WORDS_LAST) begin
            word_cnt <= '0;
            last_wr  <= 1'b1;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end else begin
          slot <= slot + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bram_comm_unit.sv
// BRAM bridge: kernel/image reader and result writer operating independently.
module bram_comm_unit
  import bram_comm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] KERNEL_ADDR = DEF_KERNEL_ADDR,
  parameter logic [ADDR_WIDTH-1:0] IMAGE_ADDR = DEF_IMAGE_ADDR,
  parameter logic [ADDR_WIDTH-1:0] OUT_ADDR = DEF_OUT_ADDR,
  parameter int PIXEL_SIZE = 8,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int IMAGE_SIZE = DEF_IMAGE_SIZE,
  parameter int NUM_IMAGES = DEF_NUM_IMAGES
) (
  input  logic                                   clk,
  input  logic                                   reset,
  output logic [ADDR_WIDTH-1:0]                  rd_addr,
  input  logic [DATA_WIDTH-1:0]                  rd_data,
  input  logic                                   read_kernel,
  input  logic                                   read_image,
  input  logic                                   interrupt,
  output logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] kernel,
  output logic [PIXEL_SIZE-1:0]                  pixel,
  output logic                                   pixel_valid,
  input  logic [PIXEL_SIZE-1:0]                  wr_pixel,
  input  logic                                   wr_pixel_valid,
  output logic [ADDR_WIDTH-1:0]                  wr_addr,
  output logic [DATA_WIDTH-1:0]                  wr_data,
  output logic [3:0]                             write_enable,
  output logic                                   conv_done
);

  bram_reader #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .KERNEL_ADDR(KERNEL_ADDR), .IMAGE_ADDR(IMAGE_ADDR),
    .PIXEL_SIZE(PIXEL_SIZE), .KERNEL_SIZE(KERNEL_SIZE),
    .IMAGE_SIZE(IMAGE_SIZE), .NUM_IMAGES(NUM_IMAGES)
  ) u_reader (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .read_kernel(read_kernel), .read_image(read_image), .interrupt(interrupt),
    .kernel(kernel), .pixel(pixel), .pixel_valid(pixel_valid)
  );

  bram_writer #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .OUT_ADDR(OUT_ADDR),
    .PIXEL_SIZE(PIXEL_SIZE), .IMAGE_SIZE(IMAGE_SIZE), .NUM_IMAGES(NUM_IMAGES)
  ) u_writer (
    .clk(clk), .reset(reset), .wr_pixel(wr_pixel), .wr_pixel_valid(wr_pixel_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .write_enable(write_enable),
    .conv_done(conv_done)
  );

endmodule

// File: tb/tb_bram_comm_unit.sv
// Directed bench with a 1-cycle-latency BRAM model and pixel/write scoreboards.
module bram_sim (
  input  logic        clk,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  we
);
  logic [31:0] mem [0:2047];

  initial begin
    for (int j = 0; j < 2048; j++) mem[j] = {4{8'(j)}};
  end

  always @(posedge clk) begin
    rd_data <= mem[rd_addr[12:2]];
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[wr_addr[12:2]][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end
endmodule

module tb_bram_comm_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, read_kernel, read_image, interrupt;
  logic [31:0]     rd_addr, rd_data, wr_addr, wr_data;
  logic [8:0][31:0] kernel;
  logic [7:0]      pixel, wr_pixel;
  logic            pixel_valid, wr_pixel_valid, conv_done;
  logic [3:0]      write_enable;

  assign wr_pixel       = pixel;
  assign wr_pixel_valid = pixel_valid;

  bram_comm_unit dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .read_kernel(read_kernel), .read_image(read_image), .interrupt(interrupt),
    .kernel(kernel), .pixel(pixel), .pixel_valid(pixel_valid),
    .wr_pixel(wr_pixel), .wr_pixel_valid(wr_pixel_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .write_enable(write_enable), .conv_done(conv_done)
  );

  bram_sim u_bram (
    .clk(clk), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .we(write_enable)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_pix_q[$];
  logic [63:0] exp_wr_q[$];
  int   pix_cnt = 0, done_cnt = 0, cycle = 0, first_cyc = -1, last_cyc = -1;
  logic mon_en = 1'b0, exp_done = 1'b0;
  logic [7:0]  exp_pix;
  logic [63:0] exp_wr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pixel scoreboard, write scoreboard and conv_done timing.
  always @(negedge clk) begin
    cycle++;
    if (mon_en) begin
      if (pixel_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cycle;
        last_cyc = cycle;
        pix_cnt++;
        checks++;
        if (exp_pix_q.size() == 0) begin
          assert (exp_pix_q.size() != 0) else begin
            failures++;
            $error("FAIL pixel_unexpected got=%h expected=none", pixel);
          end
        end else begin
          exp_pix = exp_pix_q.pop_front();
          assert (pixel === exp_pix) else begin
            failures++;
            $error("FAIL pixel got=%h expected=%h", pixel, exp_pix);
          end
        end
      end
      if (write_enable !== 4'h0) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          assert (exp_wr_q.size() != 0) else begin
            failures++;
            $error("FAIL write_unexpected got=%h/%h expected=none", wr_addr, wr_data);
          end
        end else begin
          exp_wr = exp_wr_q.pop_front();
          assert ({write_enable, wr_addr, wr_data} === {4'hF, exp_wr}) else begin
            failures++;
            $error("FAIL write got=%h/%h/%h expected=f/%h/%h", write_enable, wr_addr, wr_data,
                   exp_wr[63:32], exp_wr[31:0]);
          end
        end
      end
      checks++;
      assert (conv_done === exp_done) else begin
        failures++;
        $error("FAIL conv_done got=%b expected=%b", conv_done, exp_done);
      end
      if (conv_done === 1'b1) done_cnt++;
      exp_done = (write_enable === 4'hF) && (wr_addr === 32'hA000_10BC);
    end
  end

  task automatic push_stream();
    for (int k = 0; k < 48; k++) begin
      for (int b = 0; b < 4; b++) exp_pix_q.push_back(8'(9 + k));
      exp_wr_q.push_back({32'hA000_1000 + 32'(4 * k), {4{8'(9 + k)}}});
    end
  endtask

  int p0, n;

  initial begin
    reset = 1'b0; read_kernel = 1'b0; read_image = 1'b0; interrupt = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_pixel", pixel, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_write_enable", write_enable, 0);
    chk("rst_conv_done", conv_done, 0);
    checks++;
    assert (kernel === '0) else begin
      failures++;
      $error("FAIL rst_kernel got=%h expected=0", kernel);
    end
    reset = 1'b1;
    mon_en = 1'b1;
    tick();

    // Reset in the middle of a kernel load aborts it
    read_kernel = 1'b1;
    repeat (4) tick();
    read_kernel = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_kernel0", kernel[0], 0);
    chk("midrst_kernel1", kernel[1], 0);
    repeat (3) tick();
    chk("midrst_rd_addr", rd_addr, 0);

    // Kernel load with read_kernel held 6 cycles
    read_kernel = 1'b1;
    repeat (6) tick();
    read_kernel = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 9; i++) chk($sformatf("kernel_%0d", i), kernel[i], {4{8'(i)}});
    chk("kernel_last_addr", rd_addr, 32'hA000_0020);

    // Both requests together: kernel wins, image request is dropped
    reset = 1'b0;
    tick();
    reset = 1'b1;
    p0 = pix_cnt;
    read_kernel = 1'b1; read_image = 1'b1;
    repeat (3) tick();
    read_kernel = 1'b0; read_image = 1'b0;
    repeat (20) tick();
    chk("both_kernel0", kernel[0], 32'h0000_0000);
    chk("both_kernel8", kernel[8], 32'h0808_0808);
    chk("both_no_pixels", pix_cnt - p0, 0);
    chk("both_rd_addr", rd_addr, 32'hA000_0020);

    // Uninterrupted image stream looped back into the writer
    push_stream();
    p0 = pix_cnt; first_cyc = -1; done_cnt = 0;
    read_image = 1'b1;
    tick();
    read_image = 1'b0;
    for (n = 0; n < 400 && pix_cnt < p0 + 192; n++) tick();
    repeat (6) tick();
    chk("stream_count", pix_cnt - p0, 192);
    chk("stream_span", last_cyc - first_cyc + 1, 192);
    chk("stream_pix_left", exp_pix_q.size(), 0);
    chk("stream_wr_left", exp_wr_q.size(), 0);
    chk("stream_done_cnt", done_cnt, 1);
    chk("stream_end_valid", pixel_valid, 0);
    chk("stream_end_pixel", pixel, 8'h38);
    chk("stream_end_rd_addr", rd_addr, 32'hA000_00E0);

    // Stream with a 5-cycle interrupt mid-word
    push_stream();
    p0 = pix_cnt; first_cyc = -1; done_cnt = 0;
    read_image = 1'b1;
    tick();
    read_image = 1'b0;
    for (n = 0; n < 100 && pix_cnt < p0 + 6; n++) tick();
    interrupt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("intr_valid_%0d", i), pixel_valid, 0);
    end
    interrupt = 1'b0;
    for (n = 0; n < 400 && pix_cnt < p0 + 192; n++) tick();
    repeat (6) tick();
    chk("intr_count", pix_cnt - p0, 192);
    chk("intr_span", last_cyc - first_cyc + 1, 197);
    chk("intr_pix_left", exp_pix_q.size(), 0);
    chk("intr_wr_left", exp_wr_q.size(), 0);
    chk("intr_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
